uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 136 +++++++++++++
 tb/tb_uart_rx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, mid-bit sampling, one-cycle valid / frame_err strobes.
// Define UART_RX_PARITY_EN to receive 8E1 frames and add the parity_err output.
module uart_rx #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       rx_busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t           state, next_state;
    logic             sync1, rx_s;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             tick;
    logic             stop_good, stop_bad;
`ifdef UART_RX_PARITY_EN
    logic             par_bit;
`endif

    // The start state waits half a bit so that every later sample lands mid-bit.
    assign tick = (state == START) ? (baud_cnt == HALF_LAST) : (baud_cnt == BIT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (!rx_s) next_state = START;
            START: if (tick) next_state = rx_s ? IDLE : DATA;
            DATA:  if (tick && bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                next_state = PARITY;
`else
                next_state = STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (tick) next_state = STOP;
`endif
            STOP:  if (tick) next_state = rx_s ? IDLE : BREAK;
            BREAK: if (rx_s) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        rx_busy   = (state != IDLE);
        stop_good = (state == STOP) && tick && rx_s;
        stop_bad  = (state == STOP) && tick && !rx_s;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1     <= 1'b1;
            rx_s      <= 1'b1;
            baud_cnt  <= '0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            data_out  <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            sync1     <= rx;
            rx_s      <= sync1;
            valid     <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (state == IDLE || state == BREAK || tick) baud_cnt <= '0;
            else                                         baud_cnt <= baud_cnt + 1'b1;

            if (state != DATA)  bit_idx <= 3'd0;
            else if (tick) begin
                shift[bit_idx] <= rx_s;
                bit_idx        <= bit_idx + 3'd1;
            end

`ifdef UART_RX_PARITY_EN
            if (state == PARITY && tick) par_bit <= rx_s;
            // Even parity: data bits plus parity bit must XOR to zero.
            if (stop_good) begin
                if ((^shift) == par_bit) begin
                    data_out <= shift;
                    valid    <= 1'b1;
                end else begin
                    parity_err <= 1'b1;
                end
            end
`else
            if (stop_good) begin
                data_out <= shift;
                valid    <= 1'b1;
            end
`endif
            if (stop_bad) frame_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: drives 8N1 (or 8E1 with UART_RX_PARITY_EN) frames, predicts each
// receive event from the frame contents and its start time, and checks the outputs every cycle.
module tb_uart_rx;

    localparam int CLK_FREQ = 160;
    localparam int BAUD     = 10;
    localparam int N        = CLK_FREQ / BAUD;
    localparam int HALF     = N / 2;
`ifdef UART_RX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    // Start edge is launched just after an edge, so one extra cycle on top of 2 sync + half bit + bits.
    localparam int LAT = 3 + HALF + (9 + PBITS) * N;

    typedef enum int {EV_VALID, EV_FERR, EV_PERR} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [7:0] data;
        int         t;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data_out;
    logic       valid, frame_err, rx_busy;
    logic       perr;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    assign perr = parity_err;
`else
    assign perr = 1'b0;
`endif

    ev_t        exp_q[$];
    ev_t        ev;
    logic [7:0] model_data = 8'h00;
    int         cyc = 0;
    int         n_checks = 0, n_fail = 0;
    int         valid_count = 0, ferr_count = 0, perr_count = 0, last_valid_cyc = 0;
    int         t0_a5, vc, fc;

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .data_out  (data_out),
        .valid     (valid),
        .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic check_near(input string name, input int act, input int expv, input int tol);
        n_checks++;
        if (act < expv - tol || act > expv + tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, expv, tol);
        end
    endtask

    function automatic logic [2:0] kind_bits(input ev_kind_t k);
        case (k)
            EV_VALID: return 3'b100;
            EV_FERR:  return 3'b010;
            default:  return 3'b001;
        endcase
    endfunction

    // Compare process: every receive strobe must match the oldest predicted event.
    always @(negedge clk) begin
        if (!reset) begin
            model_data = 8'h00;
        end else begin
            check("valid_and_frame_err_exclusive", {31'd0, valid & frame_err}, 0);
            if (valid || frame_err || perr) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {29'd0, valid, frame_err, perr}, 0);
                end else begin
                    ev = exp_q.pop_front();
                    check("event_kind", {29'd0, valid, frame_err, perr}, {29'd0, kind_bits(ev.kind)});
                    check_near("event_time", cyc, ev.t, 1);
                    if (ev.kind == EV_VALID) model_data = ev.data;
                end
                if (valid) begin
                    valid_count++;
                    last_valid_cyc = cyc;
                end
                if (frame_err) ferr_count++;
                if (perr) perr_count++;
            end else if (exp_q.size() != 0 && cyc > exp_q[0].t + 1) begin
                check("missing_event", cyc, exp_q[0].t);
                void'(exp_q.pop_front());
            end
            check("data_out_held", {24'd0, data_out}, {24'd0, model_data});
        end
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (N) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        rx = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Predict the event from the frame rules, then put the frame on the line.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par, input int hold_low_bits);
        ev_t e;
        e.data = d;
        e.t    = cyc + LAT;
        if (!stop)                          e.kind = EV_FERR;
        else if (PBITS == 1 && (^d) != par) e.kind = EV_PERR;
        else                                e.kind = EV_VALID;
        exp_q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PBITS == 1) drive_bit(par);
        drive_bit(stop);
        for (int i = 0; i < hold_low_bits; i++) drive_bit(1'b0);
        rx = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_data_out", {24'd0, data_out}, 0);
        check("reset_valid", {31'd0, valid}, 0);
        check("reset_frame_err", {31'd0, frame_err}, 0);
        check("reset_rx_busy", {31'd0, rx_busy}, 0);
        reset = 1'b1;
        idle(4);

        // Single frame: literal latency and data pin the model.
        t0_a5 = cyc;
        send_frame(8'hA5, 1'b1, ^8'hA5, 0);
        idle(2);
`ifdef UART_RX_PARITY_EN
        check_near("a5_latency", last_valid_cyc - t0_a5, 171, 1);
`else
        check_near("a5_latency", last_valid_cyc - t0_a5, 155, 1);
`endif
        check("a5_data", {24'd0, data_out}, 32'hA5);
        check("a5_valid_count", valid_count, 1);
        check("a5_no_frame_err", ferr_count, 0);

        // Back-to-back frames with no idle time between stop and next start.
        send_frame(8'h00, 1'b1, 1'b0, 0);
        send_frame(8'hFF, 1'b1, 1'b0, 0);
        idle(2);
        check("b2b_valid_count", valid_count, 3);
        check("b2b_data", {24'd0, data_out}, 32'hFF);

        // Short low glitch: receiver leaves IDLE, then abandons the false start.
        vc = valid_count;
        rx = 1'b0;
        repeat (HALF / 2) @(posedge clk);
        #1;
        check("glitch_busy", {31'd0, rx_busy}, 1);
        idle(2 * N);
        check("glitch_idle", {31'd0, rx_busy}, 0);
        check("glitch_no_valid", valid_count, vc);

        // Bad stop bit, line held low three bit periods: one frame_err only.
        fc = ferr_count;
        send_frame(8'h3C, 1'b0, ^8'h3C, 3);
        check("break_busy_while_low", {31'd0, rx_busy}, 1);
        idle(5);
        check("break_idle_after_high", {31'd0, rx_busy}, 0);
        check("break_one_frame_err", ferr_count - fc, 1);
        check("break_data_kept", {24'd0, data_out}, 32'hFF);

        // Reset for one cycle in the middle of data bit 4 of 8'hF3 (line stays high afterwards).
        vc = valid_count;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1 & (8'hF3 >> i));
        rx = 1'b1;
        repeat (HALF) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_data_out", {24'd0, data_out}, 0);
        check("midreset_valid", {31'd0, valid}, 0);
        check("midreset_frame_err", {31'd0, frame_err}, 0);
        check("midreset_rx_busy", {31'd0, rx_busy}, 0);
        reset = 1'b1;
        idle(5 * N);
        check("midreset_no_valid", valid_count, vc);
        send_frame(8'h5A, 1'b1, ^8'h5A, 0);
        idle(2);
        check("after_reset_data", {24'd0, data_out}, 32'h5A);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, 0);
        idle(2);
        check("par_good_data", {24'd0, data_out}, 32'h07);
        fc = perr_count;
        send_frame(8'h07, 1'b1, 1'b0, 0);
        idle(2);
        check("par_bad_pulse", perr_count - fc, 1);
`endif

        // Random frames: random data, gaps, occasional bad stop bits and bad parity.
        for (int k = 0; k < 30; k++) begin
            logic [7:0] d;
            logic       bad_stop, par;
            d        = 8'($urandom);
            bad_stop = ($urandom_range(0, 5) == 0);
            par      = (^d) ^ ($urandom_range(0, 4) == 0);
            send_frame(d, !bad_stop, par, bad_stop ? $urandom_range(0, 2) : 0);
            idle(bad_stop ? N + $urandom_range(0, N) : $urandom_range(0, N));
        end
        idle(2 * N);
        check("no_pending_events", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
